// File: rtl/add_acc_unit.sv
// Registered unsigned adder/accumulator with ADD/ACC/SAT/CLR modes behind a valid/ready handshake.
// One-cycle latency with full throughput; a held result blocks input (in_ready = !out_valid || out_ready).
module add_acc_unit #(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] y,
    output logic                 ovf
);

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_ACC = 2'b01,
        MODE_SAT = 2'b10,
        MODE_CLR = 2'b11
    } mode_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e                 state_q;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [ACC_WIDTH-1:0]   y_q, y_d;
    logic                   ovf_q, ovf_d;
    logic                   accept;
    logic [WIDTH:0]         sum_ab;
    logic [ACC_WIDTH:0]     acc_sum;

    assign in_ready = (state_q == EMPTY) || out_ready;
    assign accept   = in_valid && in_ready;

    // Extra top bit on each sum carries the SAT clip / ACC wrap indication.
    assign sum_ab  = {1'b0, a} + {1'b0, b};
    assign acc_sum = {1'b0, acc_q} + (ACC_WIDTH+1)'(sum_ab);

    always_comb begin
        acc_d = acc_q;
        y_d   = '0;
        ovf_d = 1'b0;
        case (mode_e'(mode))
            MODE_ADD: y_d = ACC_WIDTH'(sum_ab);
            MODE_ACC: begin
                acc_d = acc_sum[ACC_WIDTH-1:0];
                y_d   = acc_sum[ACC_WIDTH-1:0];
                ovf_d = acc_sum[ACC_WIDTH];
            end
            MODE_SAT: begin
                if (sum_ab[WIDTH]) begin
                    y_d   = ACC_WIDTH'({WIDTH{1'b1}});
                    ovf_d = 1'b1;
                end else begin
                    y_d   = ACC_WIDTH'(sum_ab);
                end
            end
            default: acc_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            acc_q   <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            state_q <= FULL;
            acc_q   <= acc_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
        end else if (out_ready) begin
            state_q <= EMPTY;
        end
    end

    assign out_valid = (state_q == FULL);
    assign y         = y_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_acc_unit.sv
// Directed bench for add_acc_unit (WIDTH=4, ACC_WIDTH=8) with a small accumulator model for the random run.
module tb_add_acc_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a, b;
    logic [1:0] mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       ovf;

    int vectors    = 0;
    int miscompares = 0;
    int acc_m      = 0;

    add_acc_unit #(.WIDTH(4), .ACC_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One accepted beat with out_ready high; in_valid drops right after the edge.
    task automatic send(input int av, input int bv, input int m);
        a        = 4'(av);
        b        = 4'(bv);
        mode     = 2'(m);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic model(input int av, input int bv, input int m, output int ye, output int oe);
        int s;
        s  = av + bv;
        ye = 0;
        oe = 0;
        case (m)
            0: ye = s;
            1: begin
                acc_m = acc_m + s;
                oe    = (acc_m > 255) ? 1 : 0;
                acc_m = acc_m % 256;
                ye    = acc_m;
            end
            2: begin
                ye = (s > 15) ? 15 : s;
                oe = (s > 15) ? 1 : 0;
            end
            default: acc_m = 0;
        endcase
    endtask

    initial begin
        int ye, oe, av, bv, m;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; mode = '0;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_in_ready", 32'(in_ready), 1);

        send(15, 15, 0);
        chk("add_valid", 32'(out_valid), 1);
        chk("add_y", 32'(y), 30);
        chk("add_ovf", 32'(ovf), 0);
        cyc();
        chk("add_drain", 32'(out_valid), 0);

        send(9, 8, 2);
        chk("sat_clip_y", 32'(y), 15);
        chk("sat_clip_ovf", 32'(ovf), 1);
        send(7, 8, 2);
        chk("sat_edge_y", 32'(y), 15);
        chk("sat_edge_ovf", 32'(ovf), 0);
        send(3, 4, 2);
        chk("sat_low_y", 32'(y), 7);
        chk("sat_low_ovf", 32'(ovf), 0);

        send(0, 0, 3);
        chk("clr_y", 32'(y), 0);
        chk("clr_ovf", 32'(ovf), 0);
        for (int i = 1; i <= 9; i++) begin
            send(15, 15, 1);
            chk("acc_chain_y", 32'(y), (i == 9) ? 14 : 30 * i);
            chk("acc_chain_ovf", 32'(ovf), (i == 9) ? 1 : 0);
        end

        // acc is now 14; park an ADD result and stall the consumer.
        send(1, 2, 0);
        out_ready = 1'b0;
        a = 4'd5; b = 4'd5; mode = 2'd1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 0);
            cyc();
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_y", 32'(y), 3);
            chk("bp_ovf", 32'(ovf), 0);
        end
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("bp_resume_y", 32'(y), 24);
        chk("bp_resume_valid", 32'(out_valid), 1);
        cyc();
        chk("bp_single_beat", 32'(out_valid), 0);

        acc_m = 24;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            av = $urandom_range(15, 0);
            bv = $urandom_range(15, 0);
            m  = $urandom_range(3, 0);
            a = 4'(av); b = 4'(bv); mode = 2'(m);
            model(av, bv, m, ye, oe);
            cyc();
            chk("tp_valid", 32'(out_valid), 1);
            chk("tp_y", 32'(y), ye);
            chk("tp_ovf", 32'(ovf), oe);
        end
        in_valid = 1'b0;
        cyc();
        chk("tp_drain", 32'(out_valid), 0);

        send(0, 0, 3);
        send(15, 15, 1);
        send(15, 15, 1);
        chk("pre_rst_y", 32'(y), 60);
        rst = 1'b1; out_ready = 1'b0;
        a = 4'd1; b = 4'd1; mode = 2'd1; in_valid = 1'b1;
        cyc();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_y", 32'(y), 0);
        chk("midrst_ovf", 32'(ovf), 0);
        send(1, 2, 1);
        chk("post_rst_acc_y", 32'(y), 3);
        chk("post_rst_acc_ovf", 32'(ovf), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
